// File: rtl/sim_monitor.sv
// sim_monitor: run controller and passive data-bus monitor for CPU bring-up.
// Holds the CPU in reset for RESET_CYCLES after system reset and then lets it
// run. While running it counts cycles and bus strobes. The run ends on a
// tohost write (pass/fail), an illegal access (fault) or a watchdog timeout.
// The monitor only observes the bus and never drives it.
module sim_monitor #(
    parameter int unsigned     RESET_CYCLES = 4,
    parameter longint unsigned MAX_CYCLES   = 1000,
    parameter logic [31:0]     TOHOST_ADDR  = 32'h0000_FFF0,
    parameter logic [31:0]     ADDR_LIMIT   = 32'h0001_0000,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_writedata,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic [2:0]       status,
    output logic [31:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] write_count,
    output logic [CNT_W-1:0] read_count,
    output logic [31:0]      last_addr
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_e;

    typedef enum logic [2:0] {
        ST_NONE       = 3'd0,
        ST_PASS       = 3'd1,
        ST_FAIL       = 3'd2,
        ST_TIMEOUT    = 3'd3,
        ST_MISALIGNED = 3'd4,
        ST_RANGE      = 3'd5,
        ST_RW_BOTH    = 3'd6
    } status_e;

    // Hold counter only needs to reach RESET_CYCLES-1.
    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    // Watchdog is disabled when its limit cannot be represented by the cycle
    // counter (MAX_CYCLES > 2^CNT_W) or when MAX_CYCLES is zero.
    localparam bit WD_EN = (MAX_CYCLES != 0) &&
                           ((CNT_W >= 64) || (((MAX_CYCLES - 1) >> CNT_W) == 0));
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    state_e              state_q,       state_d;
    logic [HOLD_W-1:0]   hold_cnt_q,    hold_cnt_d;
    logic                cpu_reset_q,   cpu_reset_d;
    logic                running_q,     running_d;
    logic                done_q,        done_d;
    logic                pass_q,        pass_d;
    status_e             status_q,      status_d;
    logic [31:0]         fail_code_q,   fail_code_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]    write_count_q, write_count_d;
    logic [CNT_W-1:0]    read_count_q,  read_count_d;
    logic [31:0]         last_addr_q,   last_addr_d;

    logic strobe;
    assign strobe = memwrite | memread;

    // Next-state, counter updates and run-termination decode.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cpu_reset_d   = cpu_reset_q;
        running_d     = running_q;
        done_d        = done_q;
        pass_d        = pass_q;
        status_d      = status_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        write_count_d = write_count_q;
        read_count_d  = read_count_q;
        last_addr_d   = last_addr_q;

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = S_RUN;
                    cpu_reset_d = 1'b0;
                    running_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            S_RUN: begin
                // The terminating access is itself counted and recorded.
                cycle_count_d = cycle_count_q + CNT_W'(1);
                if (memwrite) write_count_d = write_count_q + CNT_W'(1);
                if (memread)  read_count_d  = read_count_q + CNT_W'(1);
                if (strobe)   last_addr_d   = mem_addr;

                // Exit conditions in priority order.
                if (memwrite && memread) begin
                    state_d  = S_FAULT;
                    status_d = ST_RW_BOTH;
                end else if (strobe && (mem_addr >= ADDR_LIMIT)) begin
                    state_d  = S_FAULT;
                    status_d = ST_RANGE;
                end else if (strobe && (mem_addr[1:0] != 2'b00)) begin
                    state_d  = S_FAULT;
                    status_d = ST_MISALIGNED;
                end else if (memwrite && (mem_addr == TOHOST_ADDR)) begin
                    state_d = S_DONE;
                    if (mem_writedata == 32'd1) begin
                        pass_d   = 1'b1;
                        status_d = ST_PASS;
                    end else begin
                        status_d    = ST_FAIL;
                        fail_code_d = mem_writedata;
                    end
                end else if (WD_EN && (cycle_count_q == WD_LAST)) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end

                if ((state_d == S_DONE) || (state_d == S_FAULT)) begin
                    cpu_reset_d = 1'b1;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                end
            end

            default: begin
                // DONE / FAULT: everything frozen until reset.
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            cpu_reset_q   <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            status_q      <= ST_NONE;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            last_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cpu_reset_q   <= cpu_reset_d;
            running_q     <= running_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            status_q      <= status_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            last_addr_q   <= last_addr_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign status      = status_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign write_count = write_count_q;
    assign read_count  = read_count_q;
    assign last_addr   = last_addr_q;

endmodule
